// File: rtl/ahb_slave_arbiter_pkg.sv
// Shared types for the per-slave AHB arbiter: transfer encodings and arbiter states.
package ahb_slave_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_type;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'b00,
        ARB_BUSY     = 2'b01,
        ARB_HANDOVER = 2'b10
    } arb_state_type;

endpackage

// File: rtl/ahb_slave_arbiter_picker.sv
// Combinational request picker: first eligible requester searching upward from i_start with wrap.
module ahb_arb_picker #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [N-1:0]     i_mask,
    input  logic [IDX_W-1:0] i_start,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    logic [N-1:0]     w_elig;
    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_pos;

    assign w_elig = i_req & ~i_mask;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_sum   = '0;
        w_pos   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_sum = {1'b0, i_start} + (IDX_W+1)'(i);
            if (w_sum >= (IDX_W+1)'(N)) begin
                w_sum = w_sum - (IDX_W+1)'(N);
            end
            w_pos = w_sum[IDX_W-1:0];
            if (!o_valid && w_elig[w_pos]) begin
                o_valid        = 1'b1;
                o_grant[w_pos] = 1'b1;
                o_idx          = w_pos;
            end
        end
    end

endmodule

// File: rtl/ahb_slave_arbiter.sv
// Per-slave AHB arbiter with beat-limited ownership and burst preemption.
// Define ROUND_ROBIN_EN for rotating priority; otherwise the lowest index wins.
module ahb_slave_arbiter
    import ahb_slave_arbiter_pkg::*;
#(
    parameter int unsigned MASTER_NUM   = 4,
    parameter int unsigned MAX_BEATS    = 16,
    parameter int unsigned MASTER_IDX_W = $clog2(MASTER_NUM)
) (
    input  logic                    hclk,
    input  logic                    hreset,
    input  logic [MASTER_NUM-1:0]   hreq,
    input  htrans_type              htrans,
    input  logic                    hmastlock,
    input  logic                    hready,
    output logic [MASTER_NUM-1:0]   hgrant,
    output logic [MASTER_IDX_W-1:0] hmaster,
    output logic                    hsel,
    output logic                    hlast_slv
);

    localparam int unsigned CNT_W = $clog2(MAX_BEATS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS - 1);

    arb_state_type           r_state;
    logic [MASTER_NUM-1:0]   r_grant;
    logic [MASTER_IDX_W-1:0] r_master;
    logic                    r_hsel;
    logic                    r_hlast;
    logic [CNT_W-1:0]        r_beat_cnt;

    logic [MASTER_NUM-1:0]   w_mask;
    logic [MASTER_IDX_W-1:0] w_start;
    logic [MASTER_NUM-1:0]   w_pick_grant;
    logic [MASTER_IDX_W-1:0] w_pick_idx;
    logic                    w_pick_valid;
    logic                    w_owner_req;
    logic                    w_other_req;
    logic                    w_release;
    logic                    w_preempt;

`ifdef ROUND_ROBIN_EN
    logic [MASTER_IDX_W-1:0] r_rr_ptr;
    logic [MASTER_IDX_W-1:0] w_rr_next;

    assign w_start   = r_rr_ptr;
    assign w_rr_next = (w_pick_idx == MASTER_IDX_W'(MASTER_NUM - 1)) ? '0
                                                                      : w_pick_idx + MASTER_IDX_W'(1);
`else
    assign w_start = '0;
`endif

    // Only the handover pick excludes the owner whose burst was just cut.
    assign w_mask      = (r_state == ARB_HANDOVER) ? r_grant : '0;
    assign w_owner_req = |(hreq & r_grant);
    assign w_other_req = |(hreq & ~r_grant);
    assign w_release   = hready && !hmastlock && (!w_owner_req || htrans == IDLE);
    assign w_preempt   = hready && !hmastlock && htrans == SEQ &&
                         r_beat_cnt == CNT_MAX && w_other_req;

    ahb_arb_picker #(
        .N     (MASTER_NUM),
        .IDX_W (MASTER_IDX_W)
    ) u_picker (
        .i_req   (hreq),
        .i_mask  (w_mask),
        .i_start (w_start),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_state    <= ARB_IDLE;
            r_grant    <= '0;
            r_master   <= '0;
            r_hsel     <= 1'b0;
            r_hlast    <= 1'b0;
            r_beat_cnt <= '0;
`ifdef ROUND_ROBIN_EN
            r_rr_ptr   <= '0;
`endif
        end else begin
            r_hlast <= 1'b0;
            case (r_state)
                ARB_IDLE, ARB_BUSY, ARB_HANDOVER: begin
                    if (hready) begin
                        if (r_state == ARB_BUSY && !w_release) begin
                            if (w_preempt) begin
                                r_hlast <= 1'b1;
                                r_state <= ARB_HANDOVER;
                            end else if (htrans == NONSEQ) begin
                                // NONSEQ starts a new burst and is itself its first beat.
                                r_beat_cnt <= CNT_W'(1);
                            end else if (htrans == SEQ && r_beat_cnt != CNT_MAX) begin
                                r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                            end
                        end else if (w_pick_valid) begin
                            r_state    <= ARB_BUSY;
                            r_grant    <= w_pick_grant;
                            r_master   <= w_pick_idx;
                            r_hsel     <= 1'b1;
                            r_beat_cnt <= '0;
`ifdef ROUND_ROBIN_EN
                            r_rr_ptr   <= w_rr_next;
`endif
                        end else begin
                            r_state    <= ARB_IDLE;
                            r_grant    <= '0;
                            r_master   <= '0;
                            r_hsel     <= 1'b0;
                            r_beat_cnt <= '0;
                        end
                    end
                end
                default: begin
                    r_state    <= ARB_IDLE;
                    r_grant    <= '0;
                    r_master   <= '0;
                    r_hsel     <= 1'b0;
                    r_beat_cnt <= '0;
                end
            endcase
        end
    end

    assign hgrant    = r_grant;
    assign hmaster   = r_master;
    assign hsel      = r_hsel;
    assign hlast_slv = r_hlast;

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Scoreboard bench for ahb_slave_arbiter: per-cycle expectations queued with stimulus, popped after the edge.
module tb_ahb_slave_arbiter;
    import ahb_slave_arbiter_pkg::*;

    logic       hclk = 1'b0;
    logic       hreset;
    logic [3:0] hreq;
    htrans_type htrans;
    logic       hmastlock;
    logic       hready;
    logic [3:0] hgrant;
    logic [1:0] hmaster;
    logic       hsel;
    logic       hlast_slv;

    always #5 hclk = ~hclk;

    ahb_slave_arbiter #(
        .MASTER_NUM (4),
        .MAX_BEATS  (16)
    ) dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .hreq      (hreq),
        .htrans    (htrans),
        .hmastlock (hmastlock),
        .hready    (hready),
        .hgrant    (hgrant),
        .hmaster   (hmaster),
        .hsel      (hsel),
        .hlast_slv (hlast_slv)
    );

    typedef struct {
        string      tag;
        logic [3:0] grant;
        logic       hlast;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        for (int i = 0; i < 4; i++) begin
            if (g[i]) return 2'(i);
        end
        return 2'd0;
    endfunction

    task automatic step(input string tag, input logic rst, input logic [3:0] req, input htrans_type tr,
                        input logic lock, input logic rdy, input logic [3:0] eg, input logic eh);
        exp_t e;
        hreset    = rst;
        hreq      = req;
        htrans    = tr;
        hmastlock = lock;
        hready    = rdy;
        e.tag   = tag;
        e.grant = eg;
        e.hlast = eh;
        sb_q.push_back(e);
        @(posedge hclk);
        #1;
        e = sb_q.pop_front();
        check_eq({e.tag, ".hgrant"},    32'(hgrant),    32'(e.grant));
        check_eq({e.tag, ".hmaster"},   32'(hmaster),   32'(idx_of(e.grant)));
        check_eq({e.tag, ".hsel"},      32'(hsel),      32'(|e.grant));
        check_eq({e.tag, ".hlast_slv"}, 32'(hlast_slv), 32'(e.hlast));
    endtask

    logic [3:0] exp_seq [4];
    logic [3:0] prev;

    initial begin
        hreset = 1'b1; hreq = '0; htrans = IDLE; hmastlock = 1'b0; hready = 1'b1;

        step("reset0", 1, 4'b0000, IDLE, 0, 1, 4'b0000, 0);
        step("reset1", 1, 4'b0000, IDLE, 0, 1, 4'b0000, 0);
        for (int i = 0; i < 10; i++) step($sformatf("idle%0d", i), 0, 4'b0000, IDLE, 0, 1, 4'b0000, 0);

        step("single_m2", 0, 4'b0100, IDLE, 0, 1, 4'b0100, 0);
        step("single_rel", 0, 4'b0000, IDLE, 0, 1, 4'b0000, 0);
        step("idle_nrdy", 0, 4'b0001, IDLE, 0, 0, 4'b0000, 0);

        // Owner drops its request every cycle while the others keep asking.
        step("rst_rr", 1, 4'b0000, IDLE, 0, 1, 4'b0000, 0);
`ifdef ROUND_ROBIN_EN
        exp_seq = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
`else
        exp_seq = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
`endif
        prev = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            step($sformatf("order%0d", i), 0, 4'b1011 & ~prev, NONSEQ, 0, 1, exp_seq[i], 0);
            prev = exp_seq[i];
        end
        step("order_end", 0, 4'b0000, IDLE, 0, 1, 4'b0000, 0);

        // Long burst from M0 with M1 waiting: cut after beat 16.
        step("rst_pre", 1, 4'b0000, IDLE, 0, 1, 4'b0000, 0);
        step("pre_gnt", 0, 4'b0001, IDLE, 0, 1, 4'b0001, 0);
        for (int k = 1; k <= 16; k++)
            step($sformatf("pre_beat%0d", k), 0, 4'b0011, (k == 1) ? NONSEQ : SEQ, 0, 1, 4'b0001, k == 16);
        step("pre_hand", 0, 4'b0011, SEQ, 0, 1, 4'b0010, 0);
        step("pre_end", 0, 4'b0000, IDLE, 0, 1, 4'b0000, 0);

        // Locked 20-beat burst: never cut; then owner drops on a would-be preempt cycle.
        step("rst_lock", 1, 4'b0000, IDLE, 0, 1, 4'b0000, 0);
        step("lock_gnt", 0, 4'b0001, IDLE, 0, 1, 4'b0001, 0);
        for (int k = 1; k <= 20; k++)
            step($sformatf("lock_beat%0d", k), 0, 4'b0011, (k == 1) ? NONSEQ : SEQ, 1, 1, 4'b0001, 0);
        step("lock_rel", 0, 4'b0010, SEQ, 0, 1, 4'b0010, 0);
        step("lock_end", 0, 4'b0000, IDLE, 0, 1, 4'b0000, 0);

        step("rst_solo", 1, 4'b0000, IDLE, 0, 1, 4'b0000, 0);
        step("solo_gnt", 0, 4'b0001, IDLE, 0, 1, 4'b0001, 0);
        for (int k = 1; k <= 20; k++)
            step($sformatf("solo_beat%0d", k), 0, 4'b0001, (k == 1) ? NONSEQ : SEQ, 0, 1, 4'b0001, 0);
        step("solo_end", 0, 4'b0000, IDLE, 0, 1, 4'b0000, 0);

        // Owner drops while the slave stalls: grant held until hready returns.
        step("rst_nrdy", 1, 4'b0000, IDLE, 0, 1, 4'b0000, 0);
        step("nrdy_gnt", 0, 4'b0001, IDLE, 0, 1, 4'b0001, 0);
        for (int i = 0; i < 5; i++) step($sformatf("nrdy%0d", i), 0, 4'b0100, SEQ, 0, 0, 4'b0001, 0);
        step("nrdy_go", 0, 4'b0100, SEQ, 0, 1, 4'b0100, 0);
        step("nrdy_end", 0, 4'b0000, IDLE, 0, 1, 4'b0000, 0);

        step("mid_gnt", 0, 4'b0001, IDLE, 0, 1, 4'b0001, 0);
        for (int k = 1; k <= 7; k++)
            step($sformatf("mid_beat%0d", k), 0, 4'b0011, (k == 1) ? NONSEQ : SEQ, 0, 1, 4'b0001, 0);
        step("mid_reset", 1, 4'b0011, SEQ, 0, 1, 4'b0000, 0);
        step("post_reset", 0, 4'b0000, IDLE, 0, 1, 4'b0000, 0);
        step("post_gnt", 0, 4'b0010, IDLE, 0, 1, 4'b0010, 0);

        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
